// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: FSM state encoding and the
// default operand width.
package div_pkg;

  localparam int DIV_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step: shifts the next dividend bit into the
// partial remainder and subtracts the divisor if it fits.
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Trial subtraction; the borrow out of the extra top bit decides the quotient bit.
  always_comb begin
    shifted = {rem_in, dvd_bit};
    diff    = shifted - {1'b0, divisor};
    q_bit   = ~diff[WIDTH];
    rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per clock, MSB first.
// Build option: define SEQ_DIVIDER_SIGNED_EN for two's-complement operands
// and results (truncating division, remainder takes the dividend's sign);
// otherwise all operands and results are unsigned.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// CALC  | iterating, one restoring step per cycle
// DONE  | result presented, waiting for out_ready
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  div_state_e state_q, state_d;

  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_next;
  logic             cnt_tc;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             dbz_q;

  logic             accept;
  logic             dvs_zero;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] step_rem;
  logic             step_bit;
  logic [WIDTH-1:0] quo_raw;
  logic [WIDTH-1:0] quo_fin;
  logic [WIDTH-1:0] rem_fin;

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign accept      = in_valid & in_ready;
  assign dvs_zero    = (divisor == '0);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

  assign cnt_next = cnt_q - CW'(1);
  assign cnt_tc   = (cnt_next == '0);

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic quo_neg_q;
  logic rem_neg_q;

  // Divide magnitudes; the most-negative value maps to its unsigned magnitude.
  assign dvd_mag = dividend[WIDTH-1] ? ('0 - dividend) : dividend;
  assign dvs_mag = divisor[WIDTH-1]  ? ('0 - divisor)  : divisor;
`else
  assign dvd_mag = dividend;
  assign dvs_mag = divisor;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_q),
    .dvd_bit (quo_q[WIDTH-1]),
    .divisor (dvs_q),
    .rem_out (step_rem),
    .q_bit   (step_bit)
  );

  assign quo_raw = {quo_q[WIDTH-2:0], step_bit};

  // Sign fix-up of the final step, applied as the result register loads.
  always_comb begin
    quo_fin = quo_raw;
    rem_fin = step_rem;
`ifdef SEQ_DIVIDER_SIGNED_EN
    if (quo_neg_q) quo_fin = '0 - quo_raw;
    if (rem_neg_q) rem_fin = '0 - step_rem;
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = dvs_zero ? DONE : CALC;
      CALC:    if (cnt_tc) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Iteration datapath and result registers; results only change on entry to DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      quo_neg_q   <= 1'b0;
      rem_neg_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (dvs_zero) begin
              quotient_q  <= '1;
              remainder_q <= dividend;
              dbz_q       <= 1'b1;
            end else begin
              cnt_q <= CW'(WIDTH);
              rem_q <= '0;
              quo_q <= dvd_mag;
              dvs_q <= dvs_mag;
`ifdef SEQ_DIVIDER_SIGNED_EN
              quo_neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
              rem_neg_q <= dividend[WIDTH-1];
`endif
            end
          end
        end
        CALC: begin
          cnt_q <= cnt_next;
          rem_q <= step_rem;
          quo_q <= quo_raw;
          if (cnt_tc) begin
            quotient_q  <= quo_fin;
            remainder_q <= rem_fin;
            dbz_q       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Randomized self-checking bench for seq_divider (WIDTH=8). Expected results
// come from plain integer division; build with SEQ_DIVIDER_SIGNED_EN to
// exercise the signed variant.
module tb_seq_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_chk = 0;
  int n_err = 0;

  logic [W-1:0] prev_q = '0;
  logic [W-1:0] prev_r = '0;
  logic         prev_z = 1'b0;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
`ifdef SEQ_DIVIDER_SIGNED_EN
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    if (b == 0) begin
      q = '1; r = a; z = 1'b1;
    end else begin
      q = W'(sa / sb);
      r = W'(sa % sb);
      z = 1'b0;
    end
`else
    if (b == 0) begin
      q = '1; r = a; z = 1'b1;
    end else begin
      q = a / b;
      r = a % b;
      z = 1'b0;
    end
`endif
  endtask

  // One full operation: accept, latency, result, hold for `hold` cycles, handshake.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold, input string tag);
    logic [W-1:0] eq, er;
    logic         ez;
    int           lat;
    model(a, b, eq, er, ez);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    dividend = W'($urandom); divisor = W'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin
      chk({tag, "_q_stable_idle"}, 32'(quotient), 32'(prev_q));
      chk({tag, "_in_ready_busy"}, 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), (b == 0) ? 32'd1 : 32'(W + 1));
    chk({tag, "_q"}, 32'(quotient), 32'(eq));
    chk({tag, "_r"}, 32'(remainder), 32'(er));
    chk({tag, "_dbz"}, 32'(div_by_zero), 32'(ez));
    out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      dividend = W'($urandom); divisor = W'($urandom);
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
      chk({tag, "_hold_q"}, 32'(quotient), 32'(eq));
      chk({tag, "_hold_r"}, 32'(remainder), 32'(er));
      chk({tag, "_hold_dbz"}, 32'(div_by_zero), 32'(ez));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    chk({tag, "_ready_rise"}, 32'(in_ready), 32'd1);
    prev_q = eq; prev_r = er; prev_z = ez;
  endtask

  task automatic rst_test();
    int seen;
    in_valid = 1'b1; dividend = 8'd200; divisor = 8'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_q", 32'(quotient), 32'd0);
    chk("midrst_r", 32'(remainder), 32'd0);
    chk("midrst_dbz", 32'(div_by_zero), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    prev_q = '0; prev_r = '0; prev_z = 1'b0;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("midrst_abandoned", 32'(seen), 32'd0);
    run_op(8'd200, 8'd3, 1, "after_rst");
  endtask

  task automatic b2b_test();
    logic [W-1:0] a, b, eq, er;
    logic         ez, acc;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_r[$];
    int           acc_cyc[$];
    int           cyc, nacc, nres;
    logic [W-1:0] lq, lr;
    cyc = 0; nacc = 0; nres = 0;
    lq = prev_q; lr = prev_r;
    out_ready = 1'b1;
    a = W'($urandom); b = W'($urandom_range(1, 255));
    in_valid = 1'b1; dividend = a; divisor = b;
    while (nres < 3 && cyc < 100) begin
      acc = in_valid & in_ready;
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        model(a, b, eq, er, ez);
        exp_q.push_back(eq); exp_r.push_back(er);
        acc_cyc.push_back(cyc);
        nacc++;
        if (nacc < 3) begin
          a = W'($urandom); b = W'($urandom_range(1, 255));
          dividend = a; divisor = b;
        end else begin
          in_valid = 1'b0;
        end
      end
      if (out_valid) begin
        lq = exp_q.pop_front();
        lr = exp_r.pop_front();
        chk("b2b_q", 32'(quotient), 32'(lq));
        chk("b2b_r", 32'(remainder), 32'(lr));
        chk("b2b_dbz", 32'(div_by_zero), 32'd0);
        nres++;
      end
    end
    chk("b2b_results", 32'(nres), 32'd3);
    if (acc_cyc.size() == 3) begin
      chk("b2b_spacing1", 32'(acc_cyc[1] - acc_cyc[0]), 32'(W + 2));
      chk("b2b_spacing2", 32'(acc_cyc[2] - acc_cyc[1]), 32'(W + 2));
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("b2b_idle", 32'(in_ready), 32'd1);
    prev_q = lq; prev_r = lr; prev_z = 1'b0;
  endtask

  initial begin
    logic [W-1:0] a, b;
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_q", 32'(quotient), 32'd0);
    chk("rst_r", 32'(remainder), 32'd0);
    chk("rst_dbz", 32'(div_by_zero), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op(8'd100, 8'd7, 0, "d100_7");
    run_op(8'd5, 8'd0, 0, "d5_0");
    run_op(8'd255, 8'd1, 5, "d255_1");
    run_op(8'hF9, 8'd2, 1, "dm7_2");
    run_op(8'h80, 8'hFF, 0, "dmin_m1");
    run_op(8'h80, 8'h01, 0, "dmin_1");
    run_op(8'd0, 8'd9, 0, "d0_9");
    run_op(8'd3, 8'd200, 2, "dsmall_big");
    rst_test();
    b2b_test();

    for (int i = 0; i < 25; i++) begin
      a = W'($urandom);
      b = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom);
      run_op(a, b, int'($urandom_range(0, 3)), $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, setting operand and result width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 The block SHALL have ports in_valid (input, 1) and in_ready (output, 1), the operand handshake.
REQ-005 The block SHALL have ports dividend and divisor, input, WIDTH each, the operands, sampled on accept.
REQ-006 The block SHALL have ports out_valid (output, 1) and out_ready (input, 1), the result handshake.
REQ-007 The block SHALL have ports quotient and remainder, output, WIDTH each, the results.
REQ-008 The block SHALL have port div_by_zero, output, 1, flagging that the current result came from divisor == 0.

Function
REQ-009 The FSM SHALL have states IDLE, CALC and DONE; reset state IDLE.
REQ-010 in_ready SHALL be 1 only in IDLE; accept = in_valid & in_ready in cycle N.
REQ-011 On accept with divisor != 0: IDLE -> CALC, load internal iteration counter with WIDTH.
REQ-012 CALC SHALL perform one restoring shift-subtract step per cycle, MSB first; CALC -> DONE when the counter reaches 0.
REQ-013 For a nonzero divisor, out_valid SHALL first be 1 in cycle N+WIDTH+1, independent of operand values.
REQ-014 On accept with divisor == 0: IDLE -> DONE directly; out_valid=1 in cycle N+1; quotient = all ones; remainder = dividend; div_by_zero = 1.
REQ-015 In DONE, out_valid, quotient, remainder and div_by_zero SHALL hold stable until out_valid & out_ready.
REQ-016 On out_valid & out_ready: DONE -> IDLE; out_valid drops next cycle; in_ready rises the same next cycle (no same-cycle re-accept).
REQ-017 The operation SHALL satisfy dividend = quotient*divisor + remainder with remainder < divisor (unsigned).
REQ-018 in_valid asserted outside IDLE SHALL be ignored; operands are not captured.
REQ-019 quotient, remainder and div_by_zero SHALL be held constant while out_valid = 0; their values then are don't-care but not X after reset.

Reset
REQ-020 rst_n low SHALL force state IDLE, in_ready=1 after deassertion, out_valid=0, quotient=0, remainder=0, div_by_zero=0, counter=0, asynchronously.
REQ-021 Reset asserted mid-CALC or in DONE SHALL abandon the operation; no result is ever presented for it.

Configuration
REQ-022 With macro SEQ_DIVIDER_SIGNED_EN defined, operands and results SHALL be two's-complement signed; without it, all unsigned.
REQ-023 Signed mode: magnitudes divided; quotient truncates toward zero; remainder sign follows dividend; sign fix-up applied on entry to DONE with no extra latency.
REQ-024 Signed mode overflow (most-negative / -1) SHALL give quotient = most-negative value, remainder = 0, div_by_zero = 0.
REQ-025 Signed mode divide-by-zero SHALL give quotient = all ones, remainder = dividend.

Structure
REQ-026 Package div_pkg SHALL hold the FSM state encoding (IDLE=2'd0, CALC=2'd1, DONE=2'd2) and the default WIDTH constant.
REQ-027 One sub-module div_step SHALL implement a single combinational restoring step (partial remainder, divisor -> new partial remainder, quotient bit); seq_divider instantiates it once.

Verification
REQ-028 WIDTH=8, unsigned: 100/7 accepted cycle N -> out_valid cycle N+9, quotient=14, remainder=2, div_by_zero=0.
REQ-029 5/0 -> out_valid cycle N+1, quotient=0xFF, remainder=5, div_by_zero=1.
REQ-030 255/1 with out_ready low 5 cycles after out_valid -> quotient=255, remainder=0 held stable, in_ready=0 throughout; completes on out_ready=1.
REQ-031 rst_n pulsed low 3 cycles after accepting 200/3 -> out_valid never asserted for it; next 200/3 gives quotient=66, remainder=2.
REQ-032 SEQ_DIVIDER_SIGNED_EN defined: -7/2 -> quotient=0xFD (-3), remainder=0xFF (-1); -128/-1 -> quotient=0x80, remainder=0.
REQ-033 Back-to-back: in_valid held high for 3 operations with out_ready=1 -> accepts spaced exactly WIDTH+2 cycles apart, results in order.
